// File: rtl/bus_req_pkg.sv
// Shared types, defaults and helpers for the multi-channel bus request master.
package bus_req_pkg;

  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefDataW   = 64;
  localparam int unsigned DefNumCh   = 8;
  localparam int unsigned DefTimeout = 255;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  // Width of a channel index; never zero so single-channel users still get a port.
  function automatic int unsigned chan_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int unsigned DefIdxW = chan_idx_w(DefNumCh);

  typedef logic [DefIdxW-1:0] chan_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: highest priority goes to the channel after the last grant.
module rr_arbiter
  import bus_req_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  localparam int unsigned IdxW = chan_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IdxW-1:0]   grant_idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] idx;
  logic            found;

  // Scan from last_grant+1 around the ring, keeping the first requester seen.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = IdxW'((32'(last_q) + i) % NUM_CH);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  // One-hot grant, encoded index and next pointer.
  always_comb begin
    grant_o = '0;
    if (found) grant_o[idx] = 1'b1;
    grant_idx_o = idx;
    any_o       = found;
    last_d      = (advance_i && found) ? idx : last_q;
  end

  // Pointer resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= IdxW'(NUM_CH - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/bus_req_arbiter.sv
// Multi-channel request master: arbitrates client requests onto a single held
// output slot, tags each request with its channel and flags stalled requests.
module bus_req_arbiter
  import bus_req_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned NUM_CH  = DefNumCh,
  parameter int unsigned TIMEOUT = DefTimeout,
  localparam int unsigned IdxW = chan_idx_w(NUM_CH),
  localparam int unsigned CntW = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data,
  output logic                     wen,
  output logic                     ren,
  output logic [IdxW-1:0]          valid,
  input  logic                     ready,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  logic [ADDR_W-1:0] addr_arr [NUM_CH];
  logic [DATA_W-1:0] data_arr [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign addr_arr[gi] = ch_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = ch_data[gi*DATA_W +: DATA_W];
  end

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              err_q, err_d;

  logic [NUM_CH-1:0] grant;
  logic [IdxW-1:0]   g;
  logic              any_req;
  logic              slot_full, take, accept, stall;
  req_kind_e         kind;

  assign slot_full = wen_q | ren_q;
  assign take      = !slot_full || ready;
  assign accept    = take && any_req;
  assign stall     = slot_full && !ready;
  assign kind      = req_kind_e'(ch_write[g]);

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req_i       (ch_valid),
    .advance_i   (take),
    .grant_o     (grant),
    .grant_idx_o (g),
    .any_o       (any_req)
  );

  // Slot load on accept, drain on ready, otherwise hold everything stable.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wen_d  = wen_q;
    ren_d  = ren_q;
    idx_d  = idx_q;
    if (accept) begin
      addr_d = addr_arr[g];
      data_d = (kind == REQ_WRITE) ? data_arr[g] : '0;
      wen_d  = (kind == REQ_WRITE);
      ren_d  = (kind == REQ_READ);
      idx_d  = g;
    end else if (ready) begin
      wen_d = 1'b0;
      ren_d = 1'b0;
    end
  end

  // Wait counter only runs while stalled; an accept can never coincide with a stall.
  always_comb begin
    wait_d = '0;
    if (stall) wait_d = (wait_q == CntW'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
  end

  // Sticky timeout: a set in the same cycle beats a clear.
  always_comb begin
    err_d = err_q;
    if (stall && (wait_q == CntW'(TIMEOUT))) err_d = 1'b1;
    else if (err_clr)                        err_d = 1'b0;
  end

  // Slot, counter and flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      wen_q  <= 1'b0;
      ren_q  <= 1'b0;
      idx_q  <= '0;
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      wen_q  <= wen_d;
      ren_q  <= ren_d;
      idx_q  <= idx_d;
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign ch_ready    = take ? grant : '0;
  assign addr        = addr_q;
  assign data        = data_q;
  assign wen         = wen_q;
  assign ren         = ren_q;
  assign valid       = idx_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Bench for bus_req_arbiter: directed table, hand-written corner sequences and
// a randomized run against a transaction-level model.
module tb_bus_req_arbiter;

  localparam int unsigned NCH = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned TO  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_valid, ch_ready, ch_write;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     data;
  logic              wen, ren, ready, err_timeout, err_clr;
  logic [2:0]        valid;

  bus_req_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .NUM_CH  (NCH),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .ch_write    (ch_write),
    .ch_addr     (ch_addr),
    .ch_data     (ch_data),
    .addr        (addr),
    .data        (data),
    .wen         (wen),
    .ren         (ren),
    .valid       (valid),
    .ready       (ready),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] a_arr [NCH];
  logic [DW-1:0] d_arr [NCH];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW] = a_arr[i];
      ch_data[i*DW +: DW] = d_arr[i];
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic [7:0] w, input logic rdy,
                       input logic clr);
    ch_valid = v;
    ch_write = w;
    ready    = rdy;
    err_clr  = clr;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- transaction-level reference model ----------------
  logic          m_full, m_write, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_ch, m_lg, m_run;

  function automatic int pick(input logic [7:0] v);
    for (int k = 1; k <= NCH; k++) begin
      if (v[(m_lg + k) % NCH]) return (m_lg + k) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_write = 1'b0; m_err = 1'b0;
    m_addr = '0; m_data = '0; m_ch = 0; m_lg = NCH - 1; m_run = 0;
  endtask

  function automatic logic [7:0] model_ch_ready();
    int g;
    g = pick(ch_valid);
    if ((!m_full || ready) && g >= 0) return 8'(1 << g);
    return 8'h00;
  endfunction

  task automatic model_step();
    int   g;
    logic take, stall;
    g     = pick(ch_valid);
    take  = !m_full || ready;
    stall = m_full && !ready;
    // The flag trips once a request has already waited TIMEOUT stalled cycles.
    if (stall && m_run >= TO) m_err = 1'b1;
    else if (err_clr)         m_err = 1'b0;
    m_run = stall ? m_run + 1 : 0;
    if (take && g >= 0) begin
      m_full  = 1'b1;
      m_write = ch_write[g];
      m_addr  = a_arr[g];
      m_data  = ch_write[g] ? d_arr[g] : '0;
      m_ch    = g;
      m_lg    = g;
    end else if (ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic model_check();
    chk("rnd_ch_ready", 64'(ch_ready), 64'(model_ch_ready()));
    chk("rnd_wen", 64'(wen), 64'(m_full && m_write));
    chk("rnd_ren", 64'(ren), 64'(m_full && !m_write));
    chk("rnd_addr", 64'(addr), 64'(m_addr));
    chk("rnd_data", data, m_data);
    chk("rnd_valid", 64'(valid), 64'(m_ch));
    chk("rnd_err", 64'(err_timeout), 64'(m_err));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       do_rst;
    logic [7:0] v;
    logic [7:0] w;
    logic       rdy;
    logic [7:0] e_cr;
    logic       e_wen;
    logic       e_ren;
    logic [2:0] e_idx;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 8'h04, 8'h04, 1'b1, 8'h04, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 3'd2};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd2};
    tbl[3]  = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 3'd0};
    tbl[5]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1, 3'd1};
    tbl[6]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h08, 1'b0, 1'b1, 3'd2};
    tbl[7]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h10, 1'b0, 1'b1, 3'd3};
    tbl[8]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1, 3'd4};
    tbl[9]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1, 3'd5};
    tbl[10] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 3'd6};
    tbl[11] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 3'd7};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0};

    for (int i = 0; i < NCH; i++) begin
      a_arr[i] = (i == 2) ? 32'h1000 : 32'h2000 + 32'(i * 16);
      d_arr[i] = (i == 2) ? 64'hDEAD : 64'hD000 + 64'(i);
    end
    pack();
    reset = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;

    // Reset state.
    chk("rst_ch_ready", 64'(ch_ready), 64'h0);
    chk("rst_wen", 64'(wen), 64'h0);
    chk("rst_ren", 64'(ren), 64'h0);
    chk("rst_addr", 64'(addr), 64'h0);
    chk("rst_data", data, 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_err", 64'(err_timeout), 64'h0);
    tick();

    // Single write then round-robin sweep.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].do_rst) do_reset();
      drive(tbl[i].v, tbl[i].w, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_ch_ready", i), 64'(ch_ready), 64'(tbl[i].e_cr));
      chk($sformatf("tbl%0d_wen", i), 64'(wen), 64'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_ren", i), 64'(ren), 64'(tbl[i].e_ren));
      chk($sformatf("tbl%0d_valid", i), 64'(valid), 64'(tbl[i].e_idx));
      if (tbl[i].e_wen || tbl[i].e_ren) begin
        chk($sformatf("tbl%0d_addr", i), 64'(addr), 64'(a_arr[tbl[i].e_idx]));
        chk($sformatf("tbl%0d_data", i), data, tbl[i].e_wen ? d_arr[tbl[i].e_idx] : 64'h0);
      end
      tick();
    end

    // Channel 5 read stalled for 10 cycles; timeout trips along the way.
    do_reset();
    drive(8'h20, 8'h00, 1'b0, 1'b0);
    chk("stall_accept", 64'(ch_ready), 64'h20);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(8'hFF, 8'hFF, 1'b0, 1'b0);
      chk("stall_ch_ready", 64'(ch_ready), 64'h0);
      chk("stall_ren", 64'(ren), 64'h1);
      chk("stall_wen", 64'(wen), 64'h0);
      chk("stall_addr", 64'(addr), 64'(a_arr[5]));
      chk("stall_valid", 64'(valid), 64'h5);
      chk("stall_data", data, 64'h0);
      chk($sformatf("stall_err_c%0d", k), 64'(err_timeout), 64'(k >= TO + 2));
      tick();
    end
    drive(8'h00, 8'h00, 1'b1, 1'b0);
    chk("drain_ren", 64'(ren), 64'h1);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    chk("empty_ren", 64'(ren), 64'h0);
    chk("err_sticky", 64'(err_timeout), 64'h1);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b1);
    chk("err_before_clr", 64'(err_timeout), 64'h1);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    chk("err_cleared", 64'(err_timeout), 64'h0);
    tick();

    // Clear held through the set condition: set wins.
    drive(8'h08, 8'h00, 1'b0, 1'b1);
    chk("clrset_accept", 64'(ch_ready), 64'h08);
    tick();
    for (int k = 1; k <= TO + 2; k++) begin
      drive(8'h00, 8'h00, 1'b0, 1'b1);
      chk($sformatf("clrset_err_c%0d", k), 64'(err_timeout), 64'(k == TO + 2));
      tick();
    end
    drive(8'h00, 8'h00, 1'b1, 1'b1);
    tick();

    // Reset while a write is stalled with the flag set.
    drive(8'h02, 8'h02, 1'b0, 1'b0);
    chk("rstmid_accept", 64'(ch_ready), 64'h02);
    tick();
    for (int k = 1; k <= TO + 2; k++) begin
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      tick();
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    chk("rstmid_wen_pre", 64'(wen), 64'h1);
    chk("rstmid_err_pre", 64'(err_timeout), 64'h1);
    reset = 1'b1;
    #1;
    chk("rstmid_wen", 64'(wen), 64'h0);
    chk("rstmid_ren", 64'(ren), 64'h0);
    chk("rstmid_err", 64'(err_timeout), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(8'h60, 8'h00, 1'b1, 1'b0);
    chk("rstmid_first_grant", 64'(ch_ready), 64'h20);
    tick();

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCH; i++) begin
        a_arr[i] = $urandom;
        d_arr[i] = {$urandom, $urandom};
      end
      pack();
      drive(8'($urandom) & 8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 19) == 0));
      model_check();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_req_arbiter.md
# bus_req_arbiter

Parametrised multi-channel bus request master, successor to the single-channel addr/data/wen/ren/ready request port. Collects read/write requests from NUM_CH independent clients and arbitrates them round-robin onto one shared request bus. Holds each request stable until the downstream `ready` completes it. Tags every request with the issuing channel index and flags stalled transactions with a timeout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, write-data width
- NUM_CH, 8, client channel count (≥2)
- TIMEOUT, 255, max cycles a request may wait for `ready` before `err_timeout` sets (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ch_valid  in  NUM_CH  per-channel request valid
- ch_ready  out  NUM_CH  per-channel request accepted (one-hot or zero)
- ch_write  in  NUM_CH  1 = write, 0 = read
- ch_addr  in  NUM_CH*ADDR_W  packed per-channel address, channel i at [i*ADDR_W +: ADDR_W]
- ch_data  in  NUM_CH*DATA_W  packed per-channel write data
- addr  out  ADDR_W  bus address
- data  out  DATA_W  bus write data (zero for reads)
- wen  out  1  write request
- ren  out  1  read request
- valid  out  $clog2(NUM_CH)  channel index of current request
- ready  in  1  downstream completes current request this cycle
- err_timeout  out  1  sticky timeout flag
- err_clr  in  1  clears `err_timeout`

## Operation
- Single output slot; `slot_full` = `wen | ren`. At most one of `wen`/`ren` high.
- Accept condition: `take = !slot_full | ready`. When `take` and any `ch_valid`, the winner g is selected and `ch_ready[g]` = 1 combinationally in that cycle. `ch_ready` is zero otherwise.
- Winner selection is round-robin: search starts at `last_grant+1` mod NUM_CH; `last_grant` updates to g on accept. `last_grant` resets to NUM_CH-1, so channel 0 wins first.
- On accept, the slot registers `addr`, `valid` = g, and `wen` = `ch_write[g]`, `ren` = `!ch_write[g]`. It also registers `data` = `ch_data[g]` for writes, 0 for reads.
- If `ready` is high and nothing is accepted, the slot empties: `wen` = `ren` = 0. `addr`, `data` and `valid` hold their last values.
- While `slot_full & !ready`, all bus outputs hold stable. This is a protocol invariant.
- Wait counter `wait_cnt` (width $clog2(TIMEOUT+1)):
  - clears on every accept and whenever the slot is empty;
  - increments each cycle while `slot_full & !ready`, saturating at TIMEOUT.
- `err_timeout` sets when `wait_cnt` == TIMEOUT and `slot_full & !ready`. The request is not dropped; the slot keeps waiting.
- `err_clr` clears `err_timeout`. A simultaneous set condition wins over `err_clr`.

## Timing
- Reset values: `ch_ready` 0 (combinational, slot empty but no valid), `addr` 0, `data` 0, `wen` 0, `ren` 0, `valid` 0, `err_timeout` 0, `wait_cnt` 0, `last_grant` NUM_CH-1.
- Latency: request accepted in cycle N appears on the bus in cycle N+1.
- Throughput: one request per cycle when `ready` is held high (back-to-back, no bubble).
- `ready` while the slot is empty is ignored.
- Reset mid-transaction empties the slot immediately (asynchronous); the in-flight request is lost.
- `ch_valid` deasserting before acceptance is permitted; it simply withdraws the request.

## Structure
- Shared package `bus_req_pkg`:
  - `req_kind_e` (`REQ_READ`, `REQ_WRITE`);
  - `chan_idx_t` typedef helper function;
  - default-width localparams.
- Sub-module `rr_arbiter` (NUM_CH request vector, `advance` input → one-hot grant plus encoded index). It owns `last_grant` and is reused by other multi-client blocks.
- Top holds the output slot, wait counter and error flag.

## Test plan
- Reset, then channel 2 writes addr 0x1000 data 0xDEAD with `ready`=1 → `ch_ready`=0b100 same cycle. Next cycle `wen`=1, `addr`=0x1000, `data`=0xDEAD, `valid`=2. Slot empty the cycle after.
- All 8 channels valid, `ready` held 1 → grants 0,1,…,7,0 on consecutive cycles. `valid` sequence matches, one per cycle, no bubble.
- Channel 5 read with `ready`=0 for 10 cycles → `ren`=1, `addr`/`valid`=5 stable for all 10 cycles, `data`=0. No other `ch_ready` during the stall.
- TIMEOUT=4, `ready` stuck 0 → `err_timeout` rises on the 5th stall cycle and stays high after `ready` returns. `err_clr` pulse drops it.
- `err_clr` asserted in the same cycle as the set condition → `err_timeout` = 1.
- Reset asserted while a write is stalled → `wen`, `ren` and `err_timeout` go to 0 immediately. First request after reset is granted to the lowest valid channel.
